// File: rtl/debug_pkg.sv
// Shared command/response byte values and the controller state encoding
// used by the UART debug controller and its bench.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam logic [7:0] RSP_ACK        = 8'h4B;
  localparam logic [7:0] RSP_ERR        = 8'h3F;
  localparam logic [7:0] RSP_TRAIL_HALT = 8'hFF;
  localparam logic [7:0] RSP_TRAIL_RUN  = 8'h00;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_CNT,
    LOAD_DATA,
    LOAD_ACK,
    RUN,
    STEP,
    STEP_WAIT,
    DUMP_ADDR,
    DUMP_CAP,
    DUMP_TX,
    DUMP_TRAIL,
    ERR_TX
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Splits one DATA_WIDTH word into BYTE_WIDTH bytes, LSB first, over a
// valid/ready handshake; pulses done the cycle after the last byte is taken.
module word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  output logic [BYTE_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  done
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW    = $clog2(BYTES) + 1;

  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         left;

  assign data = shift[BYTE_WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      left  <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shift <= word;
        left  <= CW'(BYTES);
        valid <= 1'b1;
      end else if (valid && ready) begin
        shift <= shift >> BYTE_WIDTH;
        left  <= left - CW'(1);
        if (left == CW'(1)) begin
          valid <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_controller.sv
// UART debug controller: parses host commands, loads instruction memory,
// runs/steps the core and streams PC, registers and data memory back.
module debug_controller
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int NB_REGS    = 32,
  parameter int MEM_WORDS  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [BYTE_WIDTH-1:0] i_rx_byte,
  input  logic                  i_rx_valid,
  output logic [BYTE_WIDTH-1:0] o_tx_byte,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic                  i_finish,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [4:0]            o_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_reg_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_start,
  output logic                  o_step,
  output logic                  o_reg_send,
  output logic                  o_mem_send
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW   = $clog2(BYTES) + 1;
  localparam int WORDS = 1 + NB_REGS + MEM_WORDS;
  localparam int ICW   = $clog2(WORDS) + 1;

  state_t                state;
  logic [8:0]            word_total;
  logic [8:0]            word_idx;
  logic [BCW-1:0]        byte_idx;
  logic [DATA_WIDTH-1:0] assembly;
  logic [DATA_WIDTH-1:0] assembled;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [ICW-1:0]        dump_idx;
  logic [ICW-1:0]        idx_next;
  logic [BYTE_WIDTH-1:0] single_byte;
  logic                  single_valid;
  logic [BYTE_WIDTH-1:0] ser_byte;
  logic                  ser_valid;
  logic                  ser_done;
  logic                  ser_load;
  logic [DATA_WIDTH-1:0] ser_word;
  logic                  rx_load, rx_run, rx_step, rx_dump, rx_halt;
  logic                  go_dump;
  logic                  next_reg_send, next_mem_send;
  logic [4:0]            next_reg_addr;
  logic [ADDR_WIDTH-1:0] next_mem_addr;

  assign rx_load = i_rx_byte == BYTE_WIDTH'(CMD_LOAD);
  assign rx_run  = i_rx_byte == BYTE_WIDTH'(CMD_RUN);
  assign rx_step = i_rx_byte == BYTE_WIDTH'(CMD_STEP);
  assign rx_dump = i_rx_byte == BYTE_WIDTH'(CMD_DUMP);
  assign rx_halt = i_rx_valid && (i_rx_byte == BYTE_WIDTH'(CMD_HALT));

  // Dump word 0 is the captured PC, then registers, then data memory.
  always_comb begin
    idx_next      = dump_idx + ICW'(1);
    next_reg_send = idx_next <= ICW'(NB_REGS);
    next_mem_send = (idx_next > ICW'(NB_REGS)) && (idx_next < ICW'(WORDS));
    next_reg_addr = next_reg_send ? 5'(idx_next - ICW'(1)) : 5'd0;
    next_mem_addr = next_mem_send ? ADDR_WIDTH'(idx_next - ICW'(NB_REGS + 1)) : '0;
    assembled     = (assembly >> BYTE_WIDTH)
                  | (DATA_WIDTH'(i_rx_byte) << (DATA_WIDTH - BYTE_WIDTH));
    ser_load      = state == DUMP_CAP;
    ser_word      = (dump_idx == '0) ? pc_q : (o_reg_send ? i_reg_data : i_mem_data);
    go_dump       = ((state == IDLE) && i_rx_valid && rx_dump)
                  || ((state == RUN) && (i_finish || rx_halt))
                  || ((state == STEP) && !o_step)
                  || (state == STEP_WAIT);
  end

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_serializer (
    .clk  (i_clock),
    .rst  (i_reset),
    .load (ser_load),
    .word (ser_word),
    .ready(i_tx_ready),
    .data (ser_byte),
    .valid(ser_valid),
    .done (ser_done)
  );

  assign o_tx_valid = ser_valid | single_valid;
  assign o_tx_byte  = ser_valid ? ser_byte : single_byte;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      word_total    <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      assembly      <= '0;
      pc_q          <= '0;
      dump_idx      <= '0;
      single_byte   <= '0;
      single_valid  <= 1'b0;
      o_reg_addr    <= '0;
      o_mem_addr    <= '0;
      o_instruccion <= '0;
      o_address     <= '0;
      o_loading     <= 1'b0;
      o_start       <= 1'b0;
      o_step        <= 1'b0;
      o_reg_send    <= 1'b0;
      o_mem_send    <= 1'b0;
    end else begin
      o_loading <= 1'b0;
      o_step    <= 1'b0;
      unique case (state)
        IDLE: if (i_rx_valid) begin
          if (rx_load) state <= LOAD_CNT;
          else if (rx_run) begin
            state   <= RUN;
            o_start <= 1'b1;
          end else if (rx_step) begin
            state  <= STEP;
            o_step <= !i_finish;
          end else if (!rx_dump) begin
            state        <= ERR_TX;
            single_byte  <= BYTE_WIDTH'(RSP_ERR);
            single_valid <= 1'b1;
          end
        end
        LOAD_CNT: if (i_rx_valid) begin
          word_total <= (i_rx_byte == '0) ? 9'd256 : 9'(i_rx_byte);
          word_idx   <= '0;
          byte_idx   <= '0;
          state      <= LOAD_DATA;
        end
        LOAD_DATA: if (i_rx_valid) begin
          assembly <= assembled;
          if (byte_idx == BCW'(BYTES - 1)) begin
            byte_idx      <= '0;
            o_instruccion <= assembled;
            o_address     <= ADDR_WIDTH'(word_idx) << 2;
            o_loading     <= 1'b1;
            word_idx      <= word_idx + 9'd1;
            if (word_idx + 9'd1 == word_total) begin
              state        <= LOAD_ACK;
              single_byte  <= BYTE_WIDTH'(RSP_ACK);
              single_valid <= 1'b1;
            end
          end else begin
            byte_idx <= byte_idx + BCW'(1);
          end
        end
        LOAD_ACK, ERR_TX, DUMP_TRAIL: if (i_tx_ready) begin
          single_valid <= 1'b0;
          state        <= IDLE;
        end
        RUN:       if (i_finish || rx_halt) o_start <= 1'b0;
        STEP:      if (o_step) state <= STEP_WAIT;
        STEP_WAIT: state <= STEP_WAIT;
        DUMP_ADDR: state <= DUMP_CAP;
        DUMP_CAP:  state <= DUMP_TX;
        DUMP_TX: if (ser_done) begin
          if (idx_next == ICW'(WORDS)) begin
            state        <= DUMP_TRAIL;
            single_byte  <= BYTE_WIDTH'(i_finish ? RSP_TRAIL_HALT : RSP_TRAIL_RUN);
            single_valid <= 1'b1;
            o_reg_send   <= 1'b0;
            o_mem_send   <= 1'b0;
          end else begin
            state      <= DUMP_ADDR;
            dump_idx   <= idx_next;
            o_reg_send <= next_reg_send;
            o_mem_send <= next_mem_send;
            o_reg_addr <= next_reg_addr;
            o_mem_addr <= next_mem_addr;
          end
        end
        default: state <= IDLE;
      endcase
      // Every path into the dump shares this entry: PC captured, index cleared.
      if (go_dump) begin
        state      <= DUMP_ADDR;
        pc_q       <= i_pc;
        dump_idx   <= '0;
        o_reg_send <= 1'b0;
        o_mem_send <= 1'b0;
        o_reg_addr <= '0;
        o_mem_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed-plus-random bench for debug_controller: a RAM model feeds the dump,
// and expected TX streams are rebuilt from the register/memory contents.
module tb_debug_controller;
  import debug_pkg::*;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int NR    = 32;
  localparam int MW    = 32;
  localparam int AW    = 32;
  localparam int TOTAL = (DW / BW) * (1 + NR + MW) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] rx_byte;
  logic          rx_valid;
  logic [BW-1:0] tx_byte;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          finish;
  logic [DW-1:0] pc;
  logic [4:0]    reg_addr;
  logic [DW-1:0] reg_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] instr;
  logic [AW-1:0] address;
  logic          loading, start, step, reg_send, mem_send;

  always #5 clk = ~clk;

  debug_controller #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .NB_REGS(NR), .MEM_WORDS(MW), .ADDR_WIDTH(AW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_tx_byte(tx_byte), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .i_finish(finish), .i_pc(pc), .o_reg_addr(reg_addr), .i_reg_data(reg_rd),
    .o_mem_addr(mem_addr), .i_mem_data(mem_rd), .o_instruccion(instr),
    .o_address(address), .o_loading(loading), .o_start(start), .o_step(step),
    .o_reg_send(reg_send), .o_mem_send(mem_send)
  );

  logic [DW-1:0] reg_model [NR];
  logic [DW-1:0] mem_model [MW];

  // Register file and data memory answer one cycle after the address.
  always_ff @(posedge clk) begin
    reg_rd <= reg_model[reg_addr];
    mem_rd <= mem_model[mem_addr[4:0]];
  end

  int   tx_mode = 0;
  int   tx_phase = 0;
  always @(posedge clk) begin
    #1;
    tx_phase = (tx_phase + 1) % 3;
    tx_ready = (tx_mode == 0) ? 1'b1 : (tx_phase == 0);
  end

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] ld_addr_q[$];
  logic [31:0] ld_word_q[$];
  int          step_cnt = 0, hold_viol = 0, overlap_cnt = 0, reg_cycles = 0, mem_cycles = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_byte = '0;

  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold && (!tx_valid || tx_byte !== prev_byte)) hold_viol++;
      prev_hold = tx_valid && !tx_ready;
      prev_byte = tx_byte;
      if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
      if (loading) begin
        ld_addr_q.push_back(address);
        ld_word_q.push_back(instr);
      end
      if (step) step_cnt++;
      if (reg_send) reg_cycles++;
      if (mem_send) mem_cycles++;
      if (reg_send && mem_send) overlap_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_queues();
    tx_q.delete();
    ld_addr_q.delete();
    ld_word_q.delete();
  endtask

  // Expected dump: PC, registers, memory as LSB-first bytes, then trailer.
  task automatic build_dump(input logic [31:0] pc_v, input logic fin);
    logic [31:0] words[$];
    exp_q.delete();
    words.push_back(pc_v);
    for (int i = 0; i < NR; i++) words.push_back(reg_model[i]);
    for (int i = 0; i < MW; i++) words.push_back(mem_model[i]);
    foreach (words[w]) for (int b = 0; b < 4; b++) exp_q.push_back(words[w][8*b +: 8]);
    exp_q.push_back(fin ? 8'hFF : 8'h00);
  endtask

  task automatic check_stream(input string tag);
    int bad = TOTAL;
    for (int i = TOTAL - 1; i >= 0; i--)
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad = i;
    check({tag, "_len"}, tx_q.size(), TOTAL);
    check({tag, "_first_bad_idx"}, bad, TOTAL);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NR; i++) reg_model[i] = 32'(i * 2);
    for (int i = 0; i < MW; i++) mem_model[i] = 32'(i + 32'h100);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NR; i++) reg_model[i] = $urandom;
    for (int i = 0; i < MW; i++) mem_model[i] = $urandom;
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] w;
    int cnt;
    int bad;

    rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; finish = 1'b0; pc = '0;
    fill_pattern();
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs",
          {tx_valid, start, step, loading, reg_send, mem_send, tx_byte}, '0);
    check("reset_data_outputs", {instr, address}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Reset part-way through a word, then a clean single-word load.
    send(CMD_LOAD); send(8'h01); send(8'hEF); send(8'hBE);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midload_reset_outputs", {tx_valid, loading, start}, '0);
    rst = 1'b0;
    check("midload_no_partial_write", ld_word_q.size(), 0);
    clear_queues();
    send(CMD_LOAD); send(8'h01);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_tx(1, 50);
    check("load1_count", ld_word_q.size(), 1);
    check("load1_word", ld_word_q[0], 32'h1234_5678);
    check("load1_addr", ld_addr_q[0], 32'h0);
    check("load1_ack_count", tx_q.size(), 1);
    check("load1_ack", tx_q[0], RSP_ACK);

    // Three random words.
    clear_queues();
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    send(CMD_LOAD); send(8'h03);
    foreach (words[i]) for (int b = 0; b < 4; b++) begin
      w = words[i];
      send(w[8*b +: 8]);
    end
    wait_tx(1, 50);
    check("load3_count", ld_word_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("load3_addr%0d", i), ld_addr_q[i], 32'(i * 4));
      check($sformatf("load3_word%0d", i), ld_word_q[i], words[i]);
    end
    check("load3_ack_count", tx_q.size(), 1);
    check("load3_ack", tx_q[0], RSP_ACK);

    // N = 0 loads 256 words.
    clear_queues();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    send(CMD_LOAD); send(8'h00);
    foreach (words[i]) for (int b = 0; b < 4; b++) begin
      w = words[i];
      send(w[8*b +: 8]);
    end
    wait_tx(1, 50);
    check("load256_count", ld_word_q.size(), 256);
    bad = 256;
    for (int i = 255; i >= 0; i--)
      if (i >= ld_word_q.size() || ld_word_q[i] !== words[i] || ld_addr_q[i] !== 32'(i * 4))
        bad = i;
    check("load256_first_bad_idx", bad, 256);
    check("load256_ack", {tx_q.size(), tx_q[0]}, {32'd1, RSP_ACK});

    // Single step then dump, fixed pattern.
    clear_queues();
    fill_pattern();
    pc = 32'h10; finish = 1'b0; step_cnt = 0; reg_cycles = 0; mem_cycles = 0; overlap_cnt = 0;
    send(CMD_STEP);
    wait_tx(TOTAL, 4000);
    check("step_pulses", step_cnt, 1);
    check("step_first_word", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h10);
    check("step_trailer", tx_q[tx_q.size() - 1], 8'h00);
    build_dump(32'h10, 1'b0);
    check_stream("step_dump");
    check("step_phase_flags_seen", {reg_cycles > 0, mem_cycles > 0}, 2'b11);
    check("step_phase_overlap", overlap_cnt, 0);

    // Run until the core halts.
    clear_queues();
    fill_random();
    pc = $urandom;
    send(CMD_RUN);
    cnt = 0;
    repeat (50) begin
      if (start) cnt++;
      @(negedge clk);
    end
    finish = 1'b1;
    @(negedge clk);
    check("run_start_dropped", start, 1'b0);
    check("run_start_cycles", cnt, 50);
    build_dump(pc, 1'b1);
    wait_tx(TOTAL, 4000);
    check_stream("run_dump");
    check("run_trailer", tx_q[tx_q.size() - 1], 8'hFF);
    finish = 1'b0;

    // Host halt, with a stray byte dropped mid-run.
    clear_queues();
    fill_random();
    pc = $urandom;
    send(CMD_RUN);
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (start) cnt++;
      if (i == 9) send(CMD_LOAD);
      else @(negedge clk);
    end
    send(CMD_HALT);
    check("halt_start_dropped", start, 1'b0);
    check("halt_start_cycles", cnt, 19);
    build_dump(pc, 1'b0);
    wait_tx(TOTAL, 4000);
    check_stream("halt_dump");
    check("halt_trailer", tx_q[tx_q.size() - 1], 8'h00);

    // Unknown command, then a throttled dump.
    clear_queues();
    send(8'h7A);
    wait_tx(1, 50);
    check("err_count", tx_q.size(), 1);
    check("err_byte", tx_q[0], RSP_ERR);
    clear_queues();
    fill_pattern();
    pc = 32'h10;
    hold_viol = 0;
    tx_mode = 1;
    send(CMD_DUMP);
    wait_tx(TOTAL, 8000);
    tx_mode = 0;
    build_dump(32'h10, 1'b0);
    check_stream("throttled_dump");
    check("throttled_hold_violations", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
